// File: rtl/clint_unit_if.sv
// clint_unit_if: data-bus port of clint_unit (en_i strobe, we_i byte enables with 0000 = read, addr_i byte offset, data_i write data, data_o read data)
interface clint_unit_if;
  logic        en_i;
  logic [3:0]  we_i;
  logic [4:0]  addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  modport master (output en_i, we_i, addr_i, data_i, input data_o);
  modport slave  (input en_i, we_i, addr_i, data_i, output data_o);
endinterface

// File: rtl/clint_unit.sv
// clint_unit: core-local interrupt source (64-bit MTIME/MTIMECMP timer, MSIP, maskable external bank with claim); ports clk, reset_n (sync active-low), bus (clint_unit_if.slave), ext_irq_i, mtime_o, msi_o, mti_o, mei_o; define EXT_IRQ_SYNC_EN to put a 2-flop synchronizer in front of ext_irq_i edge detection
module clint_unit #(
  parameter int NUM_EXT_SRC = 8,
  parameter int PRESCALER   = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  clint_unit_if.slave            bus,
  input  logic [NUM_EXT_SRC-1:0] ext_irq_i,
  output logic [63:0]            mtime_o,
  output logic                   msi_o,
  output logic                   mti_o,
  output logic                   mei_o
);
  typedef logic [NUM_EXT_SRC-1:0] ext_t;
  localparam int PW = PRESCALER > 1 ? $clog2(PRESCALER) : 1;
  logic [PW-1:0] pcnt;
  logic [63:0]   mtime, mtimecmp, mtime_n, cmp_n;
  logic [31:0]   wmask, rdata;
  logic [5:0]    claim_id;
  logic [2:0]    idx;
  logic          msip, wr, rd, tick, mt_wr, cmp_wr, claim_rd;
  ext_t          pend, enable, hist, samp, pe, claim_mask, clr, pend_n, enable_n;
  logic          unused;
  function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] d, input logic [31:0] m);
    return (o & ~m) | (d & m);
  endfunction
  assign unused   = ^bus.addr_i[1:0];
  assign idx      = bus.addr_i[4:2];
  assign wr       = bus.en_i & (|bus.we_i);
  assign rd       = bus.en_i & ~(|bus.we_i);
  assign wmask    = {{8{bus.we_i[3]}}, {8{bus.we_i[2]}}, {8{bus.we_i[1]}}, {8{bus.we_i[0]}}};
  assign tick     = pcnt == PW'(PRESCALER - 1);
  assign mt_wr    = wr & (idx[2:1] == 2'b00);
  assign cmp_wr   = wr & (idx[2:1] == 2'b01);
  assign claim_rd = rd & (idx == 3'd7);
  // a write to either half freezes the other half for that cycle instead of incrementing it
  assign mtime_n = mt_wr ? {idx[0] ? mrg(mtime[63:32], bus.data_i, wmask) : mtime[63:32],
                            idx[0] ? mtime[31:0] : mrg(mtime[31:0], bus.data_i, wmask)}
                         : mtime + 64'(tick);
  assign cmp_n   = cmp_wr ? {idx[0] ? mrg(mtimecmp[63:32], bus.data_i, wmask) : mtimecmp[63:32],
                             idx[0] ? mtimecmp[31:0] : mrg(mtimecmp[31:0], bus.data_i, wmask)}
                          : mtimecmp;
`ifdef EXT_IRQ_SYNC_EN
  ext_t s1, s2;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= ext_irq_i;
      s2 <= s1;
    end
  end
  assign samp = s2;
`else
  assign samp = ext_irq_i;
`endif
  assign pe = pend & enable;
  always_comb begin
    claim_id   = '0;
    claim_mask = '0;
    for (int i = NUM_EXT_SRC - 1; i >= 0; i--) begin
      if (pe[i]) begin
        claim_id   = 6'(i + 1);
        claim_mask = ext_t'(1) << i;
      end
    end
  end
  assign clr      = (claim_rd ? claim_mask : '0) | ((wr && idx == 3'd5) ? ext_t'(bus.data_i & wmask) : '0);
  // new edge is OR-ed in after clearing so a coincident request is never lost
  assign pend_n   = (pend & ~clr) | (samp & ~hist);
  assign enable_n = (wr && idx == 3'd6) ? ext_t'(mrg(32'(enable), bus.data_i, wmask)) : enable;
  always_comb begin
    rdata = '0;
    case (idx)
      3'd0: rdata = mtime[31:0];
      3'd1: rdata = mtime[63:32];
      3'd2: rdata = mtimecmp[31:0];
      3'd3: rdata = mtimecmp[63:32];
      3'd4: rdata = {31'b0, msip};
      3'd5: rdata = 32'(pend);
      3'd6: rdata = 32'(enable);
      3'd7: rdata = 32'(claim_id);
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mtime      <= '0;
      mtimecmp   <= '1;
      msip       <= 1'b0;
      pend       <= '0;
      enable     <= '0;
      hist       <= '0;
      pcnt       <= '0;
      bus.data_o <= '0;
      mti_o      <= 1'b0;
      mei_o      <= 1'b0;
    end else begin
      mtime    <= mtime_n;
      mtimecmp <= cmp_n;
      if (wr && idx == 3'd4 && bus.we_i[0]) msip <= bus.data_i[0];
      pend     <= pend_n;
      enable   <= enable_n;
      hist     <= samp;
      pcnt     <= (mt_wr || tick) ? '0 : pcnt + PW'(1);
      if (rd) bus.data_o <= rdata;
      mti_o    <= mtime_n >= cmp_n;
      mei_o    <= |(pend_n & enable_n);
    end
  end
  assign mtime_o = mtime;
  assign msi_o   = msip;
endmodule
